// File: rtl/line_buffer3_if.sv
// line_buffer3_if
// Pixel stream and row-tap bundle between a raster source, line_buffer3 and
// the 3x3 window stage that consumes the row taps.
//   sof, pix_valid, pix_in : raster pixel stream into the line buffer
//   out_l1/out_l2/out_l3   : rows r-2, r-1 and r at the same column
//   wr_sft_en              : shift strobe for the window stage
//   win_valid              : the shift completes a full 3x3 window
//   frame_done             : one-cycle pulse after the last pixel of a frame
// Modports: master = pixel source / tap consumer, slave = line buffer.
interface line_buffer3_if #(
  parameter int BIT_DEPTH = 8
);
  logic                 sof;
  logic                 pix_valid;
  logic [BIT_DEPTH-1:0] pix_in;
  logic [BIT_DEPTH-1:0] out_l1;
  logic [BIT_DEPTH-1:0] out_l2;
  logic [BIT_DEPTH-1:0] out_l3;
  logic                 wr_sft_en;
  logic                 win_valid;
  logic                 frame_done;

  modport master (
    output sof, pix_valid, pix_in,
    input  out_l1, out_l2, out_l3, wr_sft_en, win_valid, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output out_l1, out_l2, out_l3, wr_sft_en, win_valid, frame_done
  );
endinterface

// File: rtl/line_buffer3.sv
// line_buffer3
// Feeds a 3x3 sliding-window stage from a raster-order pixel stream. Two
// circular line memories hold the previous two rows; each accepted pixel
// yields the vertically aligned triple (r-2, r-1, r) one cycle later.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : line_buffer3_if.slave (pixel stream in, row taps and strobes out)
// Optional build macro LINEBUF_BORDER_PAD_EN: zero top padding, so shifts
// start at row 0 with missing upper rows presented as zero.
module line_buffer3 #(
  parameter int BIT_DEPTH  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input logic           clk,
  input logic           rst,
  line_buffer3_if.slave bus
);
  // Width and height are at least 3, so both counters are at least 2 bits.
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_RUN  = RW'(2);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        col, col_nxt, col_pix;
  logic [RW-1:0]        row, row_nxt, row_pix;
  logic                 accept, sft_nxt, win_nxt, done_nxt;
  logic [BIT_DEPTH-1:0] lb0 [IMG_WIDTH];
  logic [BIT_DEPTH-1:0] lb1 [IMG_WIDTH];
  logic [BIT_DEPTH-1:0] rd0, rd1, l1_nxt, l2_nxt;
  logic [BIT_DEPTH-1:0] l1_p1, l2_p1, l3_p1;
  logic                 vld_p1, win_p1, done_p1;

  // A qualified sof places the pixel at (0,0) whatever the counters say.
  assign col_pix = bus.sof ? '0 : col;
  assign row_pix = bus.sof ? '0 : row;
  assign rd0     = lb0[col_pix];
  assign rd1     = lb1[col_pix];

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    accept    = 1'b0;
    sft_nxt   = 1'b0;
    win_nxt   = 1'b0;
    done_nxt  = 1'b0;
    l1_nxt    = rd1;
    l2_nxt    = rd0;

    if (state == IDLE) accept = bus.pix_valid & bus.sof;
    else               accept = bus.pix_valid;

    if (accept) begin
      if (col_pix == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (row_pix == ROW_LAST) ? '0 : row_pix + 1'b1;
      end else begin
        col_nxt = col_pix + 1'b1;
        row_nxt = row_pix;
      end

      if ((row_pix == ROW_LAST) && (col_pix == COL_LAST)) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else if (row_nxt >= ROW_RUN) begin
        state_nxt = RUN;
      end else begin
        state_nxt = FILL;
      end

`ifdef LINEBUF_BORDER_PAD_EN
      sft_nxt = 1'b1;
      l1_nxt  = (row_pix < ROW_RUN) ? '0 : rd1;
      l2_nxt  = (row_pix == '0) ? '0 : rd0;
`else
      // An sof pixel seen in RUN restarts the frame, so it never shifts.
      sft_nxt = (state == RUN) && !bus.sof;
`endif
      win_nxt = sft_nxt && (col_pix >= COL_WIN);
    end
  end

  // Stage p0 -> p1: registered taps and strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      vld_p1  <= 1'b0;
      win_p1  <= 1'b0;
      done_p1 <= 1'b0;
      l1_p1   <= '0;
      l2_p1   <= '0;
      l3_p1   <= '0;
    end else begin
      state   <= state_nxt;
      col     <= col_nxt;
      row     <= row_nxt;
      vld_p1  <= sft_nxt;
      win_p1  <= win_nxt;
      done_p1 <= done_nxt;
      if (accept) begin
        l1_p1 <= l1_nxt;
        l2_p1 <= l2_nxt;
        l3_p1 <= bus.pix_in;
      end
    end
  end

  // Line memories age by one row per accepted pixel; reads above see the
  // values from before this write.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_pix] <= rd0;
      lb0[col_pix] <= bus.pix_in;
    end
  end

  assign bus.out_l1     = l1_p1;
  assign bus.out_l2     = l2_p1;
  assign bus.out_l3     = l3_p1;
  assign bus.wr_sft_en  = vld_p1;
  assign bus.win_valid  = win_p1;
  assign bus.frame_done = done_p1;
endmodule

// File: tb/tb_line_buffer3.sv
// tb_line_buffer3
// Directed bench for line_buffer3 on a 4x4 image with pixel = row*16+col.
// Observed outputs are packed as {out_l1, out_l2, out_l3, wr_sft_en,
// win_valid, frame_done}. Rows r-2/r-1 are only compared where they are
// defined (shifting rows, or padded rows when LINEBUF_BORDER_PAD_EN is set).
module tb_line_buffer3;
  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef LINEBUF_BORDER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  line_buffer3_if #(.BIT_DEPTH(BD)) bus ();

  line_buffer3 #(.BIT_DEPTH(BD), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [26:0] obs;
  assign obs = {bus.out_l1, bus.out_l2, bus.out_l3,
                bus.wr_sft_en, bus.win_valid, bus.frame_done};

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  // Expected outputs in the cycle after pixel (r,c) is accepted.
  function automatic logic [26:0] expect_pix(input int r, input int c);
    logic       sft;
    logic [7:0] l1, l2;
    sft = PAD || (r >= 2);
    l1  = (r >= 2) ? pv(r - 2, c) : 8'h00;
    l2  = (r >= 1) ? pv(r - 1, c) : 8'h00;
    return {l1, l2, pv(r, c), sft, sft && (c >= 2), (r == H - 1) && (c == W - 1)};
  endfunction

  function automatic logic [26:0] mask_pix(input int r);
    return (PAD || r >= 2) ? 27'h7ff_ffff : {16'h0000, 11'h7ff};
  endfunction

  task automatic push(input logic s, input logic v, input logic [7:0] p);
    @(negedge clk);
    bus.sof       = s;
    bus.pix_valid = v;
    bus.pix_in    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.sof = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", obs, 27'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b1, 8'h40 + 8'(i));
      n_checks++;
      if (obs !== 27'h0) begin
        n_fail++;
        $display("FAIL idle_no_sof[%0d]: got %h required %h", i, obs, 27'h0);
      end
    end
  endtask

  task automatic test_full_frame();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        push((r == 0) && (c == 0), 1'b1, pv(r, c));
        n_checks++;
        if ((obs & mask_pix(r)) !== (expect_pix(r, c) & mask_pix(r))) begin
          n_fail++;
          $display("FAIL full_frame(%0d,%0d): got %h required %h", r, c,
                   obs & mask_pix(r), expect_pix(r, c) & mask_pix(r));
        end
      end
    end
  endtask

  task automatic test_end_of_frame();
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b1, 8'h55);
      n_checks++;
      if (obs !== {8'h13, 8'h23, 8'h33, 3'b000}) begin
        n_fail++;
        $display("FAIL after_frame_hold[%0d]: got %h required %h", i, obs,
                 {8'h13, 8'h23, 8'h33, 3'b000});
      end
    end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        push((r == 0) && (c == 0), 1'b1, pv(r, c));
        n_checks++;
        if ((obs & mask_pix(r)) !== (expect_pix(r, c) & mask_pix(r))) begin
          n_fail++;
          $display("FAIL gaps_pix(%0d,%0d): got %h required %h", r, c,
                   obs & mask_pix(r), expect_pix(r, c) & mask_pix(r));
        end
        if (r >= 2) begin
          push(1'b0, 1'b0, 8'hEE);
          n_checks++;
          if (obs !== (expect_pix(r, c) & ~27'h7)) begin
            n_fail++;
            $display("FAIL gaps_hold(%0d,%0d): got %h required %h", r, c, obs,
                     expect_pix(r, c) & ~27'h7);
          end
        end
      end
    end
  endtask

  task automatic test_mid_sof();
    // Frame that gets aborted at (2,1).
    for (int k = 0; k <= 2 * W; k++) begin
      push(k == 0, 1'b1, pv(k / W, k % W));
      n_checks++;
      if ((obs & mask_pix(k / W)) !== (expect_pix(k / W, k % W) & mask_pix(k / W))) begin
        n_fail++;
        $display("FAIL pre_abort(%0d,%0d): got %h required %h", k / W, k % W,
                 obs & mask_pix(k / W), expect_pix(k / W, k % W) & mask_pix(k / W));
      end
    end
    // Restarted frame runs from (0,0) up to (3,1).
    for (int k = 0; k < 3 * W + 2; k++) begin
      push(k == 0, 1'b1, pv(k / W, k % W));
      n_checks++;
      if ((obs & mask_pix(k / W)) !== (expect_pix(k / W, k % W) & mask_pix(k / W))) begin
        n_fail++;
        $display("FAIL restart(%0d,%0d): got %h required %h", k / W, k % W,
                 obs & mask_pix(k / W), expect_pix(k / W, k % W) & mask_pix(k / W));
      end
    end
    // Asynchronous reset between clock edges.
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 27'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required %h", obs, 27'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b1, 8'h77);
      n_checks++;
      if (obs !== 27'h0) begin
        n_fail++;
        $display("FAIL post_reset_no_sof[%0d]: got %h required %h", i, obs, 27'h0);
      end
    end
    push(1'b1, 1'b1, pv(0, 0));
    n_checks++;
    if ((obs & mask_pix(0)) !== (expect_pix(0, 0) & mask_pix(0))) begin
      n_fail++;
      $display("FAIL post_reset_sof: got %h required %h", obs & mask_pix(0),
               expect_pix(0, 0) & mask_pix(0));
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_end_of_frame();
    test_gaps();
    test_mid_sof();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/line_buffer3.md
# line_buffer3

Upstream feeder for the 3x3 sliding-window register stage. Accepts a raster-order pixel stream (one pixel per valid cycle), stores the two previous image rows in circular line memories, and presents three vertically aligned pixels (rows r-2, r-1, r) plus a shift enable each accepted cycle. The window stage consumes these as its three row inputs and its shift strobe. It also reports when the shifted window is a complete 3x3 and when a frame has finished.

## Interface
- BIT_DEPTH, 8, pixel width in bits
- IMG_WIDTH, 28, pixels per row (>= 3)
- IMG_HEIGHT, 28, rows per frame (>= 3)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sof  in  1  start-of-frame; qualified by pix_valid, marks row 0 col 0
- pix_valid  in  1  pix_in valid this cycle
- pix_in  in  BIT_DEPTH  input pixel
- out_l1  out  BIT_DEPTH  pixel from row r-2, same column
- out_l2  out  BIT_DEPTH  pixel from row r-1, same column
- out_l3  out  BIT_DEPTH  pixel from row r (current)
- wr_sft_en  out  1  shift strobe for window stage
- win_valid  out  1  this shift completes a full 3x3 window
- frame_done  out  1  one-cycle pulse after last pixel of frame

## Operation
- Two line memories lb0 (row r-1) and lb1 (row r-2), IMG_WIDTH entries each; no reset on contents.
- col counter 0..IMG_WIDTH-1, row counter 0..IMG_HEIGHT-1, wrap col to 0 and increment row at col = IMG_WIDTH-1.
- On accepted pixel at column c: out_l1 <= lb1[c], out_l2 <= lb0[c], out_l3 <= pix_in; lb1[c] <= lb0[c]; lb0[c] <= pix_in (reads use pre-write values).
- FSM:
  - IDLE: pix_valid without sof ignored. pix_valid & sof -> accept as (0,0), go FILL.
  - FILL: rows 0-1; pixels written to line memories, wr_sft_en held 0. Entering row 2 -> RUN.
  - RUN: rows 2..IMG_HEIGHT-1; each accepted pixel produces wr_sft_en. Last pixel (IMG_HEIGHT-1, IMG_WIDTH-1) -> IDLE, frame_done pulses.
- pix_valid & sof in FILL or RUN: abort current frame, accept pixel as (0,0), go FILL; no frame_done for aborted frame.
- win_valid = wr_sft_en & (col of the accepted pixel >= 2).
- pix_valid low: counters, memories, state hold; outputs out_l* hold last value; strobes 0.

## Timing
- Reset values: out_l1/out_l2/out_l3 = 0, wr_sft_en = 0, win_valid = 0, frame_done = 0, col = row = 0, state IDLE.
- Latency: pixel accepted at edge N -> out_l*, wr_sft_en, win_valid valid in cycle after edge N (registered, 1 cycle).
- Window stage captures at edge N+1; its 3x3 outputs reflect a full window after edge N+1 when win_valid was high.
- frame_done high exactly one cycle, same cycle as wr_sft_en for the last pixel.
- Back-to-back pix_valid sustains one pixel per cycle; no stall/backpressure.
- Reset asserted mid-frame: immediate return to reset values; next frame needs sof.

## Configuration
- LINEBUF_BORDER_PAD_EN defined: zero top padding. wr_sft_en asserted for every accepted pixel from row 0; out_l1 forced 0 for rows 0-1, out_l2 forced 0 for row 0; win_valid = col >= 2 in any row. FILL state still tracked but does not gate output.
- Undefined: behaviour as in Operation (no output until row 2).

## Test plan
IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*16+col.
- Reset then idle: all outputs 0; pix_valid=1 with sof=0 for 5 cycles -> no strobes, outputs stay 0.
- Full frame back-to-back: no wr_sft_en for pixels 0x00-0x13; pixel 0x20 -> next cycle out_l1=0x00, out_l2=0x10, out_l3=0x20, wr_sft_en=1, win_valid=0; pixel 0x22 -> 0x02/0x12/0x22, win_valid=1.
- End of frame: pixel 0x33 -> out 0x13/0x23/0x33, win_valid=1, frame_done=1 one cycle; following pix_valid without sof ignored.
- Gaps: pix_valid toggled 1/0 through row 3 -> same values as back-to-back, strobes only in cycles after accepted pixels, outputs hold in gaps.
- Mid-frame sof at pixel (2,1): treated as (0,0), no strobes for next 8 pixels, no frame_done; async rst mid-row 3 -> outputs 0 same cycle.
- With LINEBUF_BORDER_PAD_EN: pixel 0x01 -> 0x00/0x00/0x01, wr_sft_en=1; pixel 0x12 -> 0x00/0x02/0x12, win_valid=1.
